// File: rtl/fifo_param_pkg.sv
// Shared types and width helpers for the parametrised synchronous FIFO family.
package fifo_param_pkg;

  typedef enum logic {
    FP_DROP      = 1'b0,
    FP_OVERWRITE = 1'b1
  } full_policy_e;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wrap_ctr.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps, so it never holds a value >= DEPTH.
module wrap_ctr
  import fifo_param_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ptr_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Synchronous FIFO with arbitrary depth, drop/overwrite full policy, level flags,
// one-cycle overflow/underflow pulses and a synchronous flush.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int OVERWRITE  = 0,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam full_policy_e POLICY = (OVERWRITE != 0) ? FP_OVERWRITE : FP_DROP;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
  localparam logic AF_IN_RST = (AFULL_LVL == 0);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("fifo_param: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_param: DEPTH must be >= 2");
    end
    if (AFULL_LVL > DEPTH) begin : g_bad_afull
      $error("fifo_param: AFULL_LVL must not exceed DEPTH");
    end
    if (AEMPTY_LVL >= DEPTH) begin : g_bad_aempty
      $error("fifo_param: AEMPTY_LVL must be below DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    waddr;
  logic [PW-1:0]    raddr;
  logic             is_full;
  logic             is_empty;
  logic             do_write;
  logic             do_read;

  // wen/ren are unconditional requests with no back-pressure: a write while full
  // is dropped or overwrites the oldest entry, a read while empty is ignored;
  // both cases are reported one cycle later on overflow/underflow.
  always_comb begin
    is_full  = (count == DEPTH_C);
    is_empty = (count == '0);
    do_write = wen & (~is_full | ren | (POLICY == FP_OVERWRITE));
    do_read  = (ren & ~is_empty) |
               (wen & ~ren & is_full & (POLICY == FP_OVERWRITE));
  end

  wrap_ctr #(.DEPTH(DEPTH), .W(PW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (do_write),
    .ptr   (waddr)
  );

  wrap_ctr #(.DEPTH(DEPTH), .W(PW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (do_read),
    .ptr   (raddr)
  );

  // Storage is deliberately not reset; gating keeps reset/flush cycles from landing writes.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_write) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case ({do_write, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= wen & ~ren & is_full;
      underflow <= ren & is_empty;
    end
  end

  always_comb begin
    rdata        = mem[raddr];
    full         = rst_n & is_full;
    empty        = ~rst_n | is_empty;
    almost_full  = rst_n ? (count >= AFULL_C) : AF_IN_RST;
    almost_empty = ~rst_n | (count <= AEMPTY_C);
  end

`ifdef FORMAL
  logic [CW-1:0] count_q;
  logic          live_q;
  int            ptr_diff;

  always_comb begin
    ptr_diff = (int'(waddr) - int'(raddr) + DEPTH) % DEPTH;
  end

  always_ff @(posedge clk) begin
    count_q <= count;
    live_q  <= rst_n & ~flush;
    if (rst_n) begin
      assert (count <= DEPTH_C);
      assert ((count == CW'(ptr_diff)) || ((count == DEPTH_C) && (waddr == raddr)));
      assert (!(full && empty));
      if (live_q) begin
        assert ((count == count_q) || (count == count_q + CW'(1)) ||
                (count == count_q - CW'(1)));
      end
    end
  end
`endif

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Next-generation synchronous FIFO for the formal-examples design family.
- Generalises data width and depth; DEPTH need not be a power of two.
- Adds a selectable full-write policy (drop or overwrite-oldest), almost-full/almost-empty thresholds, one-cycle error pulses and a synchronous flush.
- Single clock domain; used as a generic buffer between producer and consumer blocks.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 16: number of storage entries, >=2, any integer.
- OVERWRITE, 0: 0 = write while full is dropped; 1 = write while full overwrites the oldest entry.
- AFULL_LVL, DEPTH-2: almost_full asserts when count >= AFULL_LVL.
- AEMPTY_LVL, 2: almost_empty asserts when count <= AEMPTY_LVL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of pointers and count; storage contents are untouched
- wen  in  1  write request
- wdata  in  WIDTH  write data
- ren  in  1  read request; pops the head entry
- rdata  out  WIDTH  head entry, combinational from the read pointer (async read)
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- overflow  out  1  registered one-cycle pulse: a write arrived while full
- underflow  out  1  registered one-cycle pulse: a read arrived while empty

Behaviour:
- Reset: rst_n low at a clk edge clears waddr, raddr, count, overflow and underflow to 0. While in reset, full=0, empty=1, almost_empty=1, almost_full=(AFULL_LVL==0). Storage is not reset.
- flush (rst_n high) has the same effect as reset on the next edge and takes priority over wen/ren in that cycle.
- Pointers have width $clog2(DEPTH). Each increments by 1 and wraps from DEPTH-1 to 0. Pointers never hold a value >= DEPTH.
- Latency:
  - A write at edge N is visible on rdata at edge N when the FIFO was empty, so rdata is valid in cycle N+1.
  - count updates one edge after the request.
- Normal write (not full): store wdata at waddr, advance waddr, count+1.
- Normal read (not empty): advance raddr, count-1.
- wen & ren, 0 < count < DEPTH: both act; count unchanged.
- wen & ren while empty: write proceeds, read is ignored. count becomes 1, underflow pulses, raddr holds.
- wen & ren while full: both act, count stays DEPTH, overflow does not pulse.
- wen & !ren while full:
  - OVERWRITE=0: write is dropped, pointers and count hold, overflow pulses.
  - OVERWRITE=1: store at waddr, advance both waddr and raddr, count stays DEPTH, overflow pulses.
- ren & !wen while empty: pointers hold (no skip), count holds at 0, underflow pulses. rdata is undefined but stable.
- overflow and underflow are high for exactly the one cycle following the offending edge.
- Invariants, checked by formal asserts under `FORMAL:
  - count <= DEPTH.
  - count == (waddr - raddr) mod DEPTH, or count == DEPTH with waddr == raddr.
  - count changes by at most 1 per cycle.
  - full and empty are never both high.
- Elaboration error if AFULL_LVL > DEPTH or AEMPTY_LVL >= DEPTH.

Decomposition:
- Package fifo_param_pkg holds:
  - localparam functions for the pointer width and count width (clog2 helpers);
  - an enum full_policy_e {FP_DROP, FP_OVERWRITE} mapped to OVERWRITE.
- One sub-module, wrap_ctr: a parametrised modulo-DEPTH pointer with enable, synchronous active-low reset and synchronous clear. It is instantiated twice, for the write and read pointers.
- Storage, count logic and flags stay in the top module.

Test Plan:
- DEPTH=5, WIDTH=12: write 0x001..0x005 -> full=1, count=5, almost_full=1. Read 5 times -> rdata sequence 0x001..0x005, then empty=1.
- DEPTH=5, OVERWRITE=0, full with 0x001..0x005: write 0x0AA -> overflow pulses 1 cycle, count=5. Subsequent reads return 0x001..0x005.
- DEPTH=5, OVERWRITE=1, full with 0x001..0x005: write 0x0AA -> overflow pulses, count=5. Reads return 0x002, 0x003, 0x004, 0x005, 0x0AA.
- Empty FIFO: ren alone -> underflow pulses, raddr=0, count=0. Then wen & ren with 0x033 -> count=1, underflow pulses, next rdata=0x033.
- Drive 13 write/read pairs through DEPTH=5 with count=2 -> pointers wrap 4->0, count stays 2, data order preserved.
- count=3: assert flush, then rst_n=0 mid-stream with wen=1 -> count=0 and empty=1 on the next edge each time. No write lands during reset.
